// File: rtl/uart_core.sv
// uart_core: full-duplex 8N1 UART for the arena display FPGA.
//
// Ports:
//   clk50     in   system clock (50 MHz), rising edge
//   rst_n     in   asynchronous active-low reset
//   uart_baud in   [3:0] baud select (0..7 = 9600..921600, 8..15 = 9600)
//   rx_in     in   serial receive line, asynchronous, idles high
//   rx_data   out  [7:0] last correctly framed received byte (held)
//   tx_data   in   [7:0] byte to transmit
//   tx_out    out  serial transmit line, registered, idles high
//   test      out  [7:0] debug/LED bus
//
// Transfer semantics (there is no valid/ready pair on either side):
//   RX: a new byte is signalled only by rx_data taking a new value; a
//       repeated byte rewrites the same value and is invisible downstream.
//   TX: a frame is launched whenever the TX FSM is idle and tx_data differs
//       from the last byte it sent; values that come and go while a frame
//       is on the wire are never sent.
//
// Optional build macro UART_DEBUG_STATUS_EN: when defined, test carries
//   {rx_busy, tx_busy, framing_err_sticky, glitch_sticky, good_frames[3:0]};
//   otherwise test mirrors rx_data.
//
// FSM state is held in rx_state / tx_state for hierarchical probing.
module uart_core #(
  parameter int CLK_HZ      = 50000000,
  parameter int SYNC_STAGES = 2          // must be >= 2
) (
  input  logic       clk50,
  input  logic       rst_n,
  input  logic [3:0] uart_baud,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  input  logic [7:0] tx_data,
  output logic       tx_out,
  output logic [7:0] test
);

  // Clocks per bit, rounded to nearest; at 50 MHz this yields
  // 5208/2604/1302/868/434/217/109/54.
  localparam logic [12:0] DIV_9600   = 13'((CLK_HZ + 4800)   / 9600);
  localparam logic [12:0] DIV_19200  = 13'((CLK_HZ + 9600)   / 19200);
  localparam logic [12:0] DIV_38400  = 13'((CLK_HZ + 19200)  / 38400);
  localparam logic [12:0] DIV_57600  = 13'((CLK_HZ + 28800)  / 57600);
  localparam logic [12:0] DIV_115200 = 13'((CLK_HZ + 57600)  / 115200);
  localparam logic [12:0] DIV_230400 = 13'((CLK_HZ + 115200) / 230400);
  localparam logic [12:0] DIV_460800 = 13'((CLK_HZ + 230400) / 460800);
  localparam logic [12:0] DIV_921600 = 13'((CLK_HZ + 460800) / 921600);

  function automatic logic [12:0] baud_div(input logic [3:0] code);
    case (code)
      4'd1:    return DIV_19200;
      4'd2:    return DIV_38400;
      4'd3:    return DIV_57600;
      4'd4:    return DIV_115200;
      4'd5:    return DIV_230400;
      4'd6:    return DIV_460800;
      4'd7:    return DIV_921600;
      default: return DIV_9600;
    endcase
  endfunction

  // ---------------- rx_in synchroniser ----------------
  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   rx_s;
  logic                   rx_prev;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync <= '1;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[SYNC_STAGES-2:0], rx_in};
      rx_prev <= rx_s;
    end
  end
  assign rx_s = rx_sync[SYNC_STAGES-1];

  // ---------------- receiver ----------------
  // RX_BREAK holds off after a bad stop bit until the line is high again,
  // so a held-low line cannot be mistaken for a fresh start edge.
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  rx_state_t   rx_state, rx_state_d;
  logic [12:0] rx_cnt, rx_cnt_d, rx_div, rx_div_d;
  logic [2:0]  rx_bit, rx_bit_d;
  logic [7:0]  rx_shift, rx_shift_d;
  logic        rx_load, rx_load_d;

  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt;
    rx_div_d   = rx_div;
    rx_bit_d   = rx_bit;
    rx_shift_d = rx_shift;
    rx_load_d  = 1'b0;
    case (rx_state)
      RX_IDLE:
        if (rx_prev && !rx_s) begin
          rx_state_d = RX_START;
          rx_div_d   = baud_div(uart_baud);
          rx_cnt_d   = baud_div(uart_baud) >> 1;   // land on mid-bit
        end
      RX_START:
        if (rx_cnt == '0) begin
          if (!rx_s) begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = rx_div - 13'd1;
            rx_bit_d   = 3'd0;
          end else begin
            rx_state_d = RX_IDLE;                  // glitch, not a start bit
          end
        end else rx_cnt_d = rx_cnt - 13'd1;
      RX_DATA:
        if (rx_cnt == '0) begin
          rx_shift_d = {rx_s, rx_shift[7:1]};      // LSB arrives first
          rx_cnt_d   = rx_div - 13'd1;
          if (rx_bit == 3'd7) rx_state_d = RX_STOP;
          else                rx_bit_d   = rx_bit + 3'd1;
        end else rx_cnt_d = rx_cnt - 13'd1;
      RX_STOP:
        if (rx_cnt == '0) begin
          if (rx_s) begin
            rx_state_d = RX_IDLE;
            rx_load_d  = 1'b1;
          end else begin
            rx_state_d = RX_BREAK;
          end
        end else rx_cnt_d = rx_cnt - 13'd1;
      RX_BREAK:
        if (rx_s) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_div   <= DIV_9600;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_load  <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_div   <= rx_div_d;
      rx_bit   <= rx_bit_d;
      rx_shift <= rx_shift_d;
      rx_load  <= rx_load_d;
      if (rx_load) rx_data <= rx_shift;
    end
  end

  // ---------------- transmitter ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  tx_state_t   tx_state, tx_state_d;
  logic [12:0] tx_cnt, tx_cnt_d, tx_div, tx_div_d;
  logic [2:0]  tx_bit, tx_bit_d;
  logic [7:0]  tx_shift, tx_shift_d, last_sent, last_sent_d;
  logic        tx_out_d;

  always_comb begin
    tx_state_d  = tx_state;
    tx_cnt_d    = tx_cnt;
    tx_div_d    = tx_div;
    tx_bit_d    = tx_bit;
    tx_shift_d  = tx_shift;
    last_sent_d = last_sent;
    tx_out_d    = tx_out;
    case (tx_state)
      TX_IDLE:
        if (tx_data != last_sent) begin
          tx_state_d  = TX_START;
          last_sent_d = tx_data;
          tx_shift_d  = tx_data;
          tx_div_d    = baud_div(uart_baud);
          tx_cnt_d    = baud_div(uart_baud) - 13'd1;
          tx_out_d    = 1'b0;
        end
      TX_START:
        if (tx_cnt == '0) begin
          tx_state_d = TX_DATA;
          tx_out_d   = tx_shift[0];
          tx_shift_d = {1'b0, tx_shift[7:1]};
          tx_cnt_d   = tx_div - 13'd1;
          tx_bit_d   = 3'd0;
        end else tx_cnt_d = tx_cnt - 13'd1;
      TX_DATA:
        if (tx_cnt == '0) begin
          tx_cnt_d = tx_div - 13'd1;
          if (tx_bit == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_out_d   = 1'b1;
          end else begin
            tx_out_d   = tx_shift[0];
            tx_shift_d = {1'b0, tx_shift[7:1]};
            tx_bit_d   = tx_bit + 3'd1;
          end
        end else tx_cnt_d = tx_cnt - 13'd1;
      TX_STOP:
        if (tx_cnt == '0) tx_state_d = TX_IDLE;
        else              tx_cnt_d   = tx_cnt - 13'd1;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_div    <= DIV_9600;
      tx_bit    <= '0;
      tx_shift  <= '0;
      last_sent <= '0;
      tx_out    <= 1'b1;
    end else begin
      tx_state  <= tx_state_d;
      tx_cnt    <= tx_cnt_d;
      tx_div    <= tx_div_d;
      tx_bit    <= tx_bit_d;
      tx_shift  <= tx_shift_d;
      last_sent <= last_sent_d;
      tx_out    <= tx_out_d;
    end
  end

  // ---------------- debug bus ----------------
`ifdef UART_DEBUG_STATUS_EN
  logic       ferr_q, gerr_q;
  logic [3:0] good_cnt;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      ferr_q   <= 1'b0;
      gerr_q   <= 1'b0;
      good_cnt <= '0;
    end else begin
      if (rx_state == RX_STOP && rx_cnt == '0 && !rx_s) ferr_q <= 1'b1;
      if (rx_state == RX_START && rx_cnt == '0 && rx_s) gerr_q <= 1'b1;
      if (rx_load) good_cnt <= good_cnt + 4'd1;
    end
  end

  assign test = {rx_state != RX_IDLE, tx_state != TX_IDLE, ferr_q, gerr_q, good_cnt};
`else
  assign test = rx_data;
`endif

endmodule

// File: tb/tb_uart_core.sv
// Testbench for uart_core: directed scenarios plus randomized RX/TX traffic,
// checked against a bit-level line model kept in this file.
module tb_uart_core;

  // ---------------- clock / reset ----------------
  logic       clk50 = 1'b0;
  logic       rst_n;
  logic [3:0] uart_baud;
  logic       rx_in;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic       tx_out;
  logic [7:0] test;

  always #10 clk50 = ~clk50;

  uart_core dut (
    .clk50     (clk50),
    .rst_n     (rst_n),
    .uart_baud (uart_baud),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .tx_data   (tx_data),
    .tx_out    (tx_out),
    .test      (test)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int div_tab [8] = '{5208, 2604, 1302, 868, 434, 217, 109, 54};

  function automatic int ref_div(input logic [3:0] code);
    if (code >= 4'd8) return 5208;
    return div_tab[code[2:0]];
  endfunction

  logic [7:0] rx_exp      = 8'h00;
  int         good_frames = 0;
  logic       ferr_m      = 1'b0;
  logic       gerr_m      = 1'b0;

  logic [7:0] exp_q [$];          // bytes expected on tx_out, in order
  int         div_q [$];          // bit time for each expected frame
  logic [7:0] tx_last_m     = 8'h00;
  int         tx_frames_exp = 0;
  int         tx_frames_seen = 0;

  task automatic check_rx(input string tag);
    check(tag, rx_data, rx_exp);
`ifdef UART_DEBUG_STATUS_EN
    check({tag, "_status"}, test[5:0], {ferr_m, gerr_m, 4'(good_frames)});
`else
    check({tag, "_test"}, test, rx_exp);
`endif
  endtask

  // ---------------- drivers ----------------
  task automatic send_rx(input logic [7:0] b, input int div, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    @(negedge clk50);
    for (int i = 0; i < 10; i++) begin
      rx_in = frame[i];
      repeat (div) @(negedge clk50);
    end
    rx_in = 1'b1;
    if (stop_bit) begin
      rx_exp = b;
      good_frames++;
    end else begin
      ferr_m = 1'b1;
    end
  endtask

  task automatic tx_send(input logic [7:0] b);
    @(negedge clk50);
    tx_data = b;
    if (b != tx_last_m) begin
      exp_q.push_back(b);
      div_q.push_back(ref_div(uart_baud));
      tx_last_m = b;
      tx_frames_exp++;
    end
  endtask

  // ---------------- tx_out monitor ----------------
  initial begin : tx_mon
    logic [7:0] eb, got;
    logic [9:0] ef;
    int         d;
    logic       aborted;
    forever begin
      @(negedge clk50);
      if (rst_n && tx_out === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("tx_spurious_frame", 1, 0);
          for (int c = 0; c < 60000 && tx_out !== 1'b1; c++) @(negedge clk50);
        end else begin
          eb = exp_q.pop_front();
          d  = div_q.pop_front();
          ef = {1'b1, eb, 1'b0};
          got = 8'h00;
          aborted = 1'b0;
          tx_frames_seen++;
          // c counts clocks since the start bit appeared; bit k spans [k*d, (k+1)*d)
          for (int c = 1; c < 10 * d; c++) begin
            @(negedge clk50);
            if (!rst_n) aborted = 1'b1;
            if (!aborted && (c % d == 1 || c % d == d - 2))
              check("tx_bit", tx_out, ef[c / d]);
            if (c % d == d / 2 && c / d >= 1 && c / d <= 8) got[c / d - 1] = tx_out;
          end
          if (!aborted) check("tx_byte", got, eb);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    int         code, d;

    rst_n = 1'b0; rx_in = 1'b1; uart_baud = 4'd4; tx_data = 8'h00;
    repeat (5) @(negedge clk50);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_tx_out", tx_out, 1'b1);
    check("rst_test", test, 8'h00);
    rst_n = 1'b1;
    repeat (300) @(negedge clk50);
    check("idle_tx_out", tx_out, 1'b1);

    // 0x55 at 9600 on TX while RX receives at code 12 (also 9600).
    // tx_data wanders mid-frame and returns to 0x55: no second frame.
    uart_baud = 4'd0;
    tx_send(8'h55);
    repeat (5) @(negedge clk50);
    uart_baud = 4'd12;
    b = 8'($urandom_range(255, 0));
    fork
      begin
        send_rx(b, 5208, 1'b1);
        repeat (4) @(negedge clk50);
        check_rx("rx_code12");
      end
      begin
        repeat (20000) @(negedge clk50);
        tx_data = 8'h99;
        repeat (10000) @(negedge clk50);
        tx_data = 8'h55;
      end
    join
    repeat (20) @(negedge clk50);
    check("tx_idle_after_55", tx_out, 1'b1);
    check("tx_one_frame", tx_frames_seen, 1);

    // 115200: directed RX cases alongside random TX traffic
    uart_baud = 4'd4;
    fork
      begin
        send_rx(8'hA5, 434, 1'b1); repeat (4) @(negedge clk50); check_rx("rx_a5");
        repeat (20) @(negedge clk50);
        send_rx(8'h3C, 434, 1'b1); repeat (4) @(negedge clk50); check_rx("rx_3c");
        repeat (20) @(negedge clk50);
        send_rx(8'h5A, 434, 1'b0); repeat (50) @(negedge clk50); check_rx("rx_frame_err");
        send_rx(8'h81, 434, 1'b1); repeat (4) @(negedge clk50); check_rx("rx_81");
        repeat (20) @(negedge clk50);
        rx_in = 1'b0; repeat (100) @(negedge clk50); rx_in = 1'b1;
        gerr_m = 1'b1;
        repeat (600) @(negedge clk50);
        check_rx("rx_glitch");
      end
      begin
        for (int i = 0; i < 4; i++) begin
          tx_send(8'($urandom_range(255, 0)));
          repeat (10 * 434 + 20) @(negedge clk50);
        end
      end
    join

    // baud change mid-frame: current byte stays at 434, next at 54
    fork
      send_rx(8'hC3, 434, 1'b1);
      begin repeat (1000) @(negedge clk50); uart_baud = 4'd7; end
    join
    repeat (4) @(negedge clk50);
    check_rx("rx_baud_old");
    repeat (20) @(negedge clk50);
    send_rx(8'($urandom_range(255, 0)), 54, 1'b1);
    repeat (4) @(negedge clk50);
    check_rx("rx_baud_new");
    repeat (20) @(negedge clk50);

    // random simultaneous RX/TX at the faster rates
    for (int i = 0; i < 6; i++) begin
      code = $urandom_range(7, 5);
      uart_baud = 4'(code);
      d = ref_div(uart_baud);
      fork
        begin
          send_rx(8'($urandom_range(255, 0)), d, $urandom_range(3, 0) != 0);
          repeat (4) @(negedge clk50);
          check_rx("rx_rand");
        end
        tx_send(8'($urandom_range(255, 0)));
      join
      repeat (11 * d + 40) @(negedge clk50);
    end

    check("tx_frames", tx_frames_seen, tx_frames_exp);
    check("tx_queue_empty", exp_q.size(), 0);

    // reset in the middle of RX and TX frames
    uart_baud = 4'd7;
    send_rx(8'hE7, 54, 1'b1);
    repeat (4) @(negedge clk50);
    check_rx("rx_e7");
    fork
      send_rx(8'h18, 54, 1'b1);
      tx_send(~tx_last_m);
      begin
        repeat (200) @(negedge clk50);
        rst_n = 1'b0;
        repeat (2) @(negedge clk50);
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_tx_out", tx_out, 1'b1);
        check("midrst_test", test, 8'h00);
      end
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
